// File: rtl/dma_pkg.sv
// Shared DMA definitions: channel count, channel index type, arbiter state
// encoding and the priority search used by the arbiter.
package dma_pkg;

    localparam int NUM_CH = 4;

    typedef logic [1:0] ch_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        GRANT = 2'd2,
        ACK   = 2'd3
    } arb_state_t;

    // First requesting channel searching upward from base, wrapping modulo NUM_CH.
    // Scanning from the far end keeps the nearest hit as the final assignment.
    function automatic ch_t pick_winner(input logic [NUM_CH-1:0] req, input ch_t base);
        ch_t idx;
        pick_winner = base;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = base + ch_t'(i);
            if (req[idx])
                pick_winner = idx;
        end
    endfunction

endpackage

// File: rtl/dma_req_sync.sv
// DREQ input capture. Define DREQ_SYNC_EN for a two-flop synchronizer;
// otherwise DREQ is registered once.
module dma_req_sync #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_dreq,
    output logic [W-1:0] o_dreq
);

`ifdef DREQ_SYNC_EN
    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_dreq;
            r_sync <= r_meta;
        end
    end
`else
    logic [W-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_sync <= '0;
        else
            r_sync <= i_dreq;
    end
`endif

    assign o_dreq = r_sync;

endmodule

// File: rtl/dma_priority_arbiter.sv
// DMA channel priority arbiter: fixed or rotating priority, masking, software
// requests and DREQ/DACK polarity. DREQ_SYNC_EN selects the two-flop DREQ sync.
module dma_priority_arbiter
    import dma_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic [NUM_CH-1:0] RequestReg,
    input  logic [NUM_CH-1:0] MaskedReg,
    input  logic              RotatingPriority,
    input  logic              DREQ_Sense,
    input  logic              DACK_Sense,
    input  logic              MemToMem,
    input  logic              PriorityGen,
    input  logic              ldAck,
    output logic [NUM_CH-1:0] DMA_Req,
    output ch_t               ActiveChannel,
    output logic              HRQ,
    output logic [NUM_CH-1:0] DACK
);

    localparam logic [NUM_CH-1:0] ONE = {{(NUM_CH-1){1'b0}}, 1'b1};

    arb_state_t        r_state, w_next;
    ch_t               r_hp;
    ch_t               r_active;
    logic [NUM_CH-1:0] r_dma_req;

    logic [NUM_CH-1:0] w_dreq_s;
    logic [NUM_CH-1:0] w_eff_raw;
    logic [NUM_CH-1:0] w_eff;
    ch_t               w_win;
    logic [NUM_CH-1:0] w_dack_oh;

    dma_req_sync #(.W(NUM_CH)) u_sync (
        .i_clk  (CLK),
        .i_rst  (RESET),
        .i_dreq (DREQ),
        .o_dreq (w_dreq_s)
    );

    // Software requests bypass the mask; mem-to-mem only ever uses channel 0.
    assign w_eff_raw = ((w_dreq_s ^ {NUM_CH{DREQ_Sense}}) & ~MaskedReg) | RequestReg;
    assign w_eff     = MemToMem ? (w_eff_raw & ONE) : w_eff_raw;
    assign w_win     = pick_winner(w_eff, RotatingPriority ? r_hp : ch_t'(0));

    always_ff @(posedge CLK) begin
        if (RESET)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (PriorityGen && (w_eff != '0)) w_next = ARB;
            ARB:   w_next = (w_eff != '0) ? GRANT : IDLE;
            GRANT: begin
                if (ldAck)
                    w_next = ACK;
                else if (!w_eff[r_active])
                    w_next = IDLE;
            end
            ACK:   if (!ldAck) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_hp      <= '0;
            r_active  <= '0;
            r_dma_req <= '0;
        end else begin
            case (r_state)
                ARB: begin
                    if (w_eff != '0) begin
                        r_active  <= w_win;
                        r_dma_req <= ONE << w_win;
                    end
                end
                GRANT: if (!ldAck && !w_eff[r_active]) r_dma_req <= '0;
                ACK: begin
                    if (!ldAck) begin
                        r_dma_req <= '0;
                        if (RotatingPriority)
                            r_hp <= r_active + ch_t'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        HRQ       = 1'b0;
        w_dack_oh = '0;
        case (r_state)
            IDLE:       HRQ = (w_eff != '0);
            ARB, GRANT: HRQ = 1'b1;
            ACK: begin
                HRQ       = 1'b1;
                w_dack_oh = ONE << r_active;
            end
            default: ;
        endcase
        // Inactive level is ~DACK_Sense; flipping the active bit gives its asserted level.
        DACK = {NUM_CH{~DACK_Sense}} ^ w_dack_oh;
    end

    assign DMA_Req       = r_dma_req;
    assign ActiveChannel = r_active;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed self-checking bench for dma_priority_arbiter; works with or without
// DREQ_SYNC_EN by allowing three cycles for DREQ to settle.
module tb_dma_priority_arbiter;
    import dma_pkg::*;

    logic              CLK;
    logic              RESET;
    logic [NUM_CH-1:0] DREQ, RequestReg, MaskedReg;
    logic              RotatingPriority, DREQ_Sense, DACK_Sense;
    logic              MemToMem, PriorityGen, ldAck;
    logic [NUM_CH-1:0] DMA_Req;
    ch_t               ActiveChannel;
    logic              HRQ;
    logic [NUM_CH-1:0] DACK;

    int n_cmp = 0;
    int n_err = 0;

    dma_priority_arbiter dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .DREQ             (DREQ),
        .RequestReg       (RequestReg),
        .MaskedReg        (MaskedReg),
        .RotatingPriority (RotatingPriority),
        .DREQ_Sense       (DREQ_Sense),
        .DACK_Sense       (DACK_Sense),
        .MemToMem         (MemToMem),
        .PriorityGen      (PriorityGen),
        .ldAck            (ldAck),
        .DMA_Req          (DMA_Req),
        .ActiveChannel    (ActiveChannel),
        .HRQ              (HRQ),
        .DACK             (DACK)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp_v);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        repeat (3) tick();
    endtask

    // Returns in GRANT: PriorityGen seen, then ARB registers the winner.
    task automatic arbitrate();
        PriorityGen = 1'b1;
        tick();
        PriorityGen = 1'b0;
        tick();
    endtask

    task automatic serve();
        ldAck = 1'b1;
        tick();
        ldAck = 1'b0;
        tick();
    endtask

    initial begin
        RESET = 1'b1; DREQ = '0; RequestReg = '0; MaskedReg = '0;
        RotatingPriority = 1'b0; DREQ_Sense = 1'b0; DACK_Sense = 1'b0;
        MemToMem = 1'b0; PriorityGen = 1'b0; ldAck = 1'b0;
        tick(); tick();
        RESET = 1'b0;
        chk("rst_dmareq", 8'(DMA_Req), 8'h0);
        chk("rst_active", 8'(ActiveChannel), 8'h0);
        chk("rst_hrq", 8'(HRQ), 8'h0);
        chk("rst_dack", 8'(DACK), 8'hF);

        // Fixed priority: lowest channel of 1010 is ch1.
        DREQ = 4'b1010; settle();
        chk("fix_hrq_idle", 8'(HRQ), 8'h1);
        PriorityGen = 1'b1; tick(); PriorityGen = 1'b0;
        chk("fix_arb_noreq", 8'(DMA_Req), 8'h0);
        tick();
        chk("fix_dmareq", 8'(DMA_Req), 8'b0010);
        chk("fix_active", 8'(ActiveChannel), 8'h1);
        chk("fix_dack_grant", 8'(DACK), 8'hF);
        ldAck = 1'b1; tick();
        chk("fix_dack_ack", 8'(DACK), 8'b1101);
        ldAck = 1'b0; tick();
        chk("fix_done_dmareq", 8'(DMA_Req), 8'h0);
        chk("fix_done_dack", 8'(DACK), 8'hF);
        DREQ = '0; settle();
        chk("fix_idle_hrq", 8'(HRQ), 8'h0);

        // Rotation: serving ch2 moves hp to 3, so 1001 picks ch3.
        RotatingPriority = 1'b1;
        DREQ = 4'b0100; settle(); arbitrate();
        chk("rot_first_active", 8'(ActiveChannel), 8'h2);
        serve();
        DREQ = 4'b1001; settle(); arbitrate();
        chk("rot_active", 8'(ActiveChannel), 8'h3);
        chk("rot_dmareq", 8'(DMA_Req), 8'b1000);
        serve();
        DREQ = '0; settle();

        // Masking and non-maskable software requests.
        RotatingPriority = 1'b0;
        MaskedReg = 4'b0001; DREQ = 4'b0001; settle();
        chk("mask_hrq", 8'(HRQ), 8'h0);
        arbitrate();
        chk("mask_no_grant", 8'(DMA_Req), 8'h0);
        RequestReg = 4'b0001; #1;
        chk("sw_hrq", 8'(HRQ), 8'h1);
        arbitrate();
        chk("sw_dmareq", 8'(DMA_Req), 8'b0001);
        chk("sw_active", 8'(ActiveChannel), 8'h0);
        serve();
        RequestReg = '0; MaskedReg = '0; DREQ = '0; settle();

        // Polarity: active-low DREQ 1011 means only ch2 requests; DACK active-high.
        DREQ_Sense = 1'b1; DACK_Sense = 1'b1; DREQ = 4'b1011; settle();
        chk("pol_dack_idle", 8'(DACK), 8'h0);
        arbitrate();
        chk("pol_active", 8'(ActiveChannel), 8'h2);
        chk("pol_dack_grant", 8'(DACK), 8'h0);
        ldAck = 1'b1; tick();
        chk("pol_dack_ack", 8'(DACK), 8'b0100);
        ldAck = 1'b0; tick();
        chk("pol_dack_done", 8'(DACK), 8'h0);
        DREQ = 4'b1111; settle();
        DREQ_Sense = 1'b0; DACK_Sense = 1'b0; DREQ = '0; settle();
        chk("pol_restore_hrq", 8'(HRQ), 8'h0);

        // Withdrawal in GRANT drops the grant without moving hp (still 0).
        RotatingPriority = 1'b1;
        DREQ = 4'b0010; settle(); arbitrate();
        chk("wd_active", 8'(ActiveChannel), 8'h1);
        DREQ = '0; settle();
        chk("wd_dmareq", 8'(DMA_Req), 8'h0);
        chk("wd_hrq", 8'(HRQ), 8'h0);
        DREQ = 4'b1001; settle(); arbitrate();
        chk("wd_hp_kept", 8'(ActiveChannel), 8'h0);
        serve();

        // hp is now 1, so ch3 wins; reset in ACK returns hp to 0.
        arbitrate();
        chk("rstack_active", 8'(ActiveChannel), 8'h3);
        ldAck = 1'b1; tick();
        chk("rstack_dack", 8'(DACK), 8'b0111);
        RESET = 1'b1; tick();
        RESET = 1'b0; ldAck = 1'b0;
        chk("rstack_dack_off", 8'(DACK), 8'hF);
        chk("rstack_dmareq", 8'(DMA_Req), 8'h0);
        chk("rstack_active0", 8'(ActiveChannel), 8'h0);
        chk("rstack_hrq", 8'(HRQ), 8'h0);
        settle(); arbitrate();
        chk("rstack_hp0", 8'(ActiveChannel), 8'h0);
        serve();
        DREQ = '0; settle();

        // Mem-to-mem keeps only ch0; 0110 yields nothing.
        RotatingPriority = 1'b0; MemToMem = 1'b1; DREQ = 4'b0110; settle();
        chk("m2m_hrq", 8'(HRQ), 8'h0);
        arbitrate();
        chk("m2m_no_grant", 8'(DMA_Req), 8'h0);
        MemToMem = 1'b0; DREQ = '0; settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
